// File: rtl/decrypt_packer_if.sv
// rtl/decrypt_packer_if.sv - handshake/bus bundle between byte source, packer and word sink
//
// Purpose: groups the byte input, flush request, word output handshake and
//          status signals of decrypt_packer.
// Parameters: N (byte lane width), DEPTH (FIFO entries, sets level width).
// Modports:
//    master - byte source / word sink side: drives in_v, in_data, flush, out_ready
//    slave  - packer side: drives out_valid, out_data, out_keep, overflow, level, drop_cnt
interface decrypt_packer_if #(
   parameter int N     = 8,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic           in_v;
   logic [N-1:0]   in_data;
   logic           flush;
   logic           out_valid;
   logic           out_ready;
   logic [4*N-1:0] out_data;
   logic [3:0]     out_keep;
   logic           overflow;
   logic [LW-1:0]  level;
   logic [15:0]    drop_cnt;

   modport master (
      output in_v, in_data, flush, out_ready,
      input  out_valid, out_data, out_keep, overflow, level, drop_cnt
   );

   modport slave (
      input  in_v, in_data, flush, out_ready,
      output out_valid, out_data, out_keep, overflow, level, drop_cnt
   );
endinterface

// File: rtl/decrypt_packer.sv
// rtl/decrypt_packer.sv - packs decrypted bytes into 4-lane words feeding an output FIFO
//
// Purpose: collects one byte per cycle into a 4-lane little-endian word, emits
//          full words or flushed partial words (with lane mask) into a FIFO of
//          DEPTH entries; drops words pushed into a full FIFO without a pop.
// Optional feature: define DECRYPT_PACKER_STATS_EN to build the saturating
//          drop counter; otherwise drop_cnt is tied to zero.
// Ports:
//    clock - rising-edge clock
//    rst   - asynchronous active-low reset
//    bus   - decrypt_packer_if slave modport (byte in, flush, word out, status)
module decrypt_packer #(
   parameter int N     = 8,
   parameter int DEPTH = 4
) (
   input  logic             clock,
   input  logic             rst,
   decrypt_packer_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2, THREE = 2'd3} cnt_e;

   cnt_e           cnt_q, cnt_d;
   logic [4*N-1:0] asm_q, asm_d;
   logic [4*N-1:0] lanes;
   logic           word_done;
   logic [3:0]     word_keep;
   logic [2:0]     n_lanes;

   // ---------------- lane counter FSM ----------------
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         cnt_q <= EMPTY;
         asm_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         asm_q <= asm_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      asm_d = lanes;
      if (word_done) begin
         cnt_d = EMPTY;
         asm_d = '0;   // keeps unused lanes of the next partial word at zero
      end else if (bus.in_v) begin
         cnt_d = cnt_e'(cnt_q + 2'd1);
      end
   end

   // The incoming byte is merged before completion so a flush in the same
   // cycle includes it.
   always_comb begin
      lanes = asm_q;
      if (bus.in_v) begin
         case (cnt_q)
            EMPTY:   lanes[N-1:0]     = bus.in_data;
            ONE:     lanes[2*N-1:N]   = bus.in_data;
            TWO:     lanes[3*N-1:2*N] = bus.in_data;
            default: lanes[4*N-1:3*N] = bus.in_data;
         endcase
      end
      n_lanes   = {1'b0, cnt_q} + {2'b00, bus.in_v};
      word_done = (bus.in_v && ((cnt_q == THREE) || bus.flush)) ||
                  (bus.flush && (cnt_q != EMPTY));
      case (n_lanes)
         3'd1:    word_keep = 4'b0001;
         3'd2:    word_keep = 4'b0011;
         3'd3:    word_keep = 4'b0111;
         3'd4:    word_keep = 4'b1111;
         default: word_keep = 4'b0000;
      endcase
   end

   // ---------------- output FIFO ----------------
   logic [4*N-1:0] mem_data_q [DEPTH];
   logic [3:0]     mem_keep_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]  level_q, level_d;
   logic           overflow_q;
   logic           full, pop, push, drop;

   assign full  = (level_q == LW'(DEPTH));
   assign pop   = bus.out_valid && bus.out_ready;
   // A pop on the same edge frees the slot, so a full FIFO still accepts.
   assign push  = word_done && (!full || pop);
   assign drop  = word_done && full && !pop;

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q    <= level_d;
         overflow_q <= drop;
      end
   end

   // Storage needs no reset: contents are only visible through out_valid gating.
   always_ff @(posedge clock) begin
      if (push) begin
         mem_data_q[wr_ptr_q] <= lanes;
         mem_keep_q[wr_ptr_q] <= word_keep;
      end
   end

   assign bus.out_valid = (level_q != '0);
   assign bus.out_data  = bus.out_valid ? mem_data_q[rd_ptr_q] : '0;
   assign bus.out_keep  = bus.out_valid ? mem_keep_q[rd_ptr_q] : 4'b0000;
   assign bus.overflow  = overflow_q;
   assign bus.level     = level_q;

`ifdef DECRYPT_PACKER_STATS_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         drop_cnt_q <= '0;
      end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_q <= drop_cnt_q + 16'd1;
      end
   end

   assign bus.drop_cnt = drop_cnt_q;
`else
   assign bus.drop_cnt = 16'h0000;
`endif

endmodule
